card_sprite_renderer: RTL and testbench

- Downstream consumer of a 512x3-bit card image memory (16x32 sprite, synchronous read, 1-cycle read latency) in the 256x240 VGA path.
- Takes the current pixel coordinate from the VGA timing stage and generates the card memory read address. It then composites the returned colour over a background colour and emits a pipelined pixel to the VGA output stage.
- Handles double-buffered card placement per frame, show/hide control, and an optional frame-counted blink.

---
 rtl/card_sprite_renderer_if.sv | 16 +
 rtl/card_sprite_renderer.sv | 209 ++++++++++++++++++++
 tb/tb_card_sprite_renderer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/card_sprite_renderer_if.sv
// Card image memory read bus.
//   rAddr   : card memory read address (renderer -> memory)
//   RE      : read enable, high only for card-hit pixels (renderer -> memory)
//   dataOut : read data, valid one cycle after rAddr (memory -> renderer)
// The master modport is the renderer side; the slave modport is the memory side.
interface card_sprite_renderer_if #(
  parameter int ADDR_W  = 9,
  parameter int COLOR_W = 3
);
  logic [ADDR_W-1:0]  rAddr;
  logic               RE;
  logic [COLOR_W-1:0] dataOut;

  modport master (output rAddr, output RE, input dataOut);
  modport slave  (input rAddr, input RE, output dataOut);
endinterface

// File: rtl/card_sprite_renderer.sv
// Card sprite renderer for the 256x240 VGA path.
// Turns the current pixel coordinate into a card-memory read address, then
// composites the returned card colour over the background colour. Card
// placement is double-buffered (pending -> current at frame_start), and the
// card can be shown, hidden, or blinked with a frame-counted half-period.
// Ports:
//   clock, reset_n           : pixel clock, asynchronous active-low reset
//   frame_start              : one-cycle pulse at the start of each frame
//   pix_valid, pix_x, pix_y  : incoming pixel coordinate and its qualifier
//   bg_color                 : background colour for the incoming pixel
//   pos_x, pos_y, pos_load   : requested card placement, captured on pos_load
//   show, blink_en           : visibility controls, sampled at frame_start
//   mem                      : card memory read bus (rAddr/RE out, dataOut in)
//   pix_color, pix_valid_out : composited pixel, 3 cycles after pix_*
//   card_hit                 : pix_color came from an opaque card pixel
module card_sprite_renderer #(
  parameter int                 CARD_W       = 16,
  parameter int                 CARD_H       = 32,
  parameter int                 ADDR_W       = 9,
  parameter int                 COLOR_W      = 3,
  parameter logic [COLOR_W-1:0] TRANSPARENT  = '0,
  parameter int                 BLINK_FRAMES = 30
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           frame_start,
  input  logic                           pix_valid,
  input  logic [8:0]                     pix_x,
  input  logic [7:0]                     pix_y,
  input  logic [COLOR_W-1:0]             bg_color,
  input  logic [8:0]                     pos_x,
  input  logic [7:0]                     pos_y,
  input  logic                           pos_load,
  input  logic                           show,
  input  logic                           blink_en,
  card_sprite_renderer_if.master         mem,
  output logic [COLOR_W-1:0]             pix_color,
  output logic                           pix_valid_out,
  output logic                           card_hit
);

  localparam int XW    = $clog2(CARD_W);
  localparam int YW    = ADDR_W - XW;
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic signed [9:0] CARD_W_S = 10'(CARD_W);
  localparam logic signed [8:0] CARD_H_S = 9'(CARD_H);

  typedef enum logic [1:0] {
    OFF = 2'd0,
    VIS = 2'd1,
    HID = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   blink_cnt, blink_cnt_nxt;

  logic [8:0]         pend_x, cur_x;
  logic [7:0]         pend_y, cur_y;

  logic signed [9:0]  dx_p0;
  logic signed [8:0]  dy_p0;
  logic               hit_p0;
  logic [ADDR_W-1:0]  addr_p0;

  logic               hit_p1, vld_p1;
  logic [COLOR_W-1:0] bg_p1;
  logic               hit_p2, vld_p2;
  logic [COLOR_W-1:0] bg_p2;
  logic               opaque_p2;

  // Placement: pos_load fills the pending pair; frame_start commits it. When
  // both arrive together the new request goes straight to the current pair.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_x <= '0;
      pend_y <= '0;
      cur_x  <= '0;
      cur_y  <= '0;
    end else begin
      if (pos_load) begin
        pend_x <= pos_x;
        pend_y <= pos_y;
      end
      if (frame_start) begin
        cur_x <= pos_load ? pos_x : pend_x;
        cur_y <= pos_load ? pos_y : pend_y;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= OFF;
      blink_cnt <= '0;
    end else begin
      state     <= state_nxt;
      blink_cnt <= blink_cnt_nxt;
    end
  end

  // Visibility FSM; it only moves on frame_start so the card never flickers
  // part-way through a frame.
  always_comb begin
    state_nxt     = state;
    blink_cnt_nxt = blink_cnt;
    if (frame_start) begin
      case (state)
        OFF: begin
          if (show) begin
            state_nxt     = VIS;
            blink_cnt_nxt = '0;
          end
        end
        VIS: begin
          if (!show) begin
            state_nxt     = OFF;
            blink_cnt_nxt = '0;
          end else if (blink_en) begin
            if (blink_cnt == CNT_LAST) begin
              state_nxt     = HID;
              blink_cnt_nxt = '0;
            end else begin
              blink_cnt_nxt = blink_cnt + CNT_W'(1);
            end
          end else begin
            blink_cnt_nxt = '0;
          end
        end
        HID: begin
          if (!show) begin
            state_nxt     = OFF;
            blink_cnt_nxt = '0;
          end else if (!blink_en) begin
            state_nxt     = VIS;
            blink_cnt_nxt = '0;
          end else if (blink_cnt == CNT_LAST) begin
            state_nxt     = VIS;
            blink_cnt_nxt = '0;
          end else begin
            blink_cnt_nxt = blink_cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt     = OFF;
          blink_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Stage 0: hit test. Offsets are signed so pixels left of / above the card
  // come out negative and miss, which also prevents any wrap-around.
  assign dx_p0   = $signed({1'b0, pix_x}) - $signed({1'b0, cur_x});
  assign dy_p0   = $signed({1'b0, pix_y}) - $signed({1'b0, cur_y});
  assign hit_p0  = pix_valid && (state == VIS) &&
                   !dx_p0[9] && (dx_p0 < CARD_W_S) &&
                   !dy_p0[8] && (dy_p0 < CARD_H_S);
  // CARD_W is a power of two, so dy*CARD_W+dx is a plain concatenation.
  assign addr_p0 = {dy_p0[YW-1:0], dx_p0[XW-1:0]};

  // Stage 1: issue the memory read, register the pixel context.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem.rAddr <= '0;
      mem.RE    <= 1'b0;
      hit_p1    <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      mem.rAddr <= hit_p0 ? addr_p0 : '0;
      mem.RE    <= hit_p0;
      hit_p1    <= hit_p0;
      vld_p1    <= pix_valid;
    end
  end

  // Stage 2: memory is producing dataOut; carry the context alongside it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_p2 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      hit_p2 <= hit_p1;
      vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge clock) begin
    bg_p1 <= bg_color;
    bg_p2 <= bg_p1;
  end

  // Stage 3: composite. Transparent card texels fall through to background;
  // invalid pixels are forced to black.
  assign opaque_p2 = vld_p2 && hit_p2 && (mem.dataOut != TRANSPARENT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pix_valid_out <= 1'b0;
      card_hit      <= 1'b0;
      pix_color     <= '0;
    end else begin
      pix_valid_out <= vld_p2;
      card_hit      <= opaque_p2;
      pix_color     <= opaque_p2 ? mem.dataOut : (vld_p2 ? bg_p2 : '0);
    end
  end

endmodule

// File: tb/tb_card_sprite_renderer.sv
module tb_card_sprite_renderer;

  localparam int BF = 2;

  logic       clock;
  logic       reset_n;
  logic       frame_start;
  logic       pix_valid;
  logic [8:0] pix_x;
  logic [7:0] pix_y;
  logic [2:0] bg_color;
  logic [8:0] pos_x;
  logic [7:0] pos_y;
  logic       pos_load;
  logic       show;
  logic       blink_en;
  logic [2:0] pix_color;
  logic       pix_valid_out;
  logic       card_hit;

  card_sprite_renderer_if #(.ADDR_W(9), .COLOR_W(3)) mem_if ();

  card_sprite_renderer #(
    .CARD_W(16), .CARD_H(32), .ADDR_W(9), .COLOR_W(3),
    .TRANSPARENT(3'b000), .BLINK_FRAMES(BF)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .frame_start(frame_start),
    .pix_valid(pix_valid),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .bg_color(bg_color),
    .pos_x(pos_x),
    .pos_y(pos_y),
    .pos_load(pos_load),
    .show(show),
    .blink_en(blink_en),
    .mem(mem_if.master),
    .pix_color(pix_color),
    .pix_valid_out(pix_valid_out),
    .card_hit(card_hit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Card image memory: synchronous read, one cycle latency.
  logic [2:0] mem [512];
  always @(posedge clock) begin
    if (mem_if.RE) mem_if.dataOut <= mem[mem_if.rAddr];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: card placement, visibility and expected output stream.
  typedef struct {
    logic       v;
    logic       h;
    logic [2:0] c;
  } exp_t;

  exp_t exp_q[$];
  int   m_pend_x, m_pend_y, m_cur_x, m_cur_y;
  logic m_on, m_vis;
  int   m_n;

  task automatic model_reset();
    exp_t z;
    z.v = 1'b0; z.h = 1'b0; z.c = 3'b000;
    m_pend_x = 0; m_pend_y = 0; m_cur_x = 0; m_cur_y = 0;
    m_on = 1'b0; m_vis = 1'b0; m_n = 0;
    exp_q.delete();
    exp_q.push_back(z);
    exp_q.push_back(z);
  endtask

  // One clock: predict from the inputs now applied, advance the model,
  // clock the DUT, then compare stage-1 and stage-3 outputs.
  task automatic cycle();
    int   dx, dy, a;
    logic h;
    exp_t e;
    dx = int'(pix_x) - m_cur_x;
    dy = int'(pix_y) - m_cur_y;
    h  = pix_valid && m_vis && dx >= 0 && dx < 16 && dy >= 0 && dy < 32;
    a  = h ? dy * 16 + dx : 0;
    e.v = pix_valid;
    e.h = h && (mem[a] != 3'b000);
    e.c = e.h ? mem[a] : (pix_valid ? bg_color : 3'b000);
    exp_q.push_back(e);

    if (frame_start) begin
      m_cur_x = pos_load ? int'(pos_x) : m_pend_x;
      m_cur_y = pos_load ? int'(pos_y) : m_pend_y;
      if (!show) begin
        m_on = 1'b0; m_vis = 1'b0; m_n = 0;
      end else if (!m_on) begin
        m_on = 1'b1; m_vis = 1'b1; m_n = 0;
      end else if (!blink_en) begin
        m_vis = 1'b1; m_n = 0;
      end else begin
        m_n++;
        if (m_n == BF) begin
          m_n = 0;
          m_vis = !m_vis;
        end
      end
    end
    if (pos_load) begin
      m_pend_x = int'(pos_x);
      m_pend_y = int'(pos_y);
    end

    @(posedge clock);
    #1;
    chk("rAddr", 32'(mem_if.rAddr), 32'(a));
    chk("RE", 32'(mem_if.RE), 32'(h));
    e = exp_q.pop_front();
    chk("pix_valid_out", 32'(pix_valid_out), 32'(e.v));
    chk("card_hit", 32'(card_hit), 32'(e.h));
    chk("pix_color", 32'(pix_color), 32'(e.c));
  endtask

  task automatic idle_inputs();
    frame_start = 1'b0;
    pos_load    = 1'b0;
    pix_valid   = 1'b0;
    pix_x       = '0;
    pix_y       = '0;
    bg_color    = 3'($urandom_range(0, 7));
  endtask

  task automatic pixel(input int x, input int y);
    frame_start = 1'b0;
    pos_load    = 1'b0;
    pix_valid   = 1'b1;
    pix_x       = 9'(x);
    pix_y       = 8'(y);
    bg_color    = 3'($urandom_range(0, 7));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rAddr"}, 32'(mem_if.rAddr), 32'd0);
    chk({tag, "_RE"}, 32'(mem_if.RE), 32'd0);
    chk({tag, "_pix_color"}, 32'(pix_color), 32'd0);
    chk({tag, "_pix_valid_out"}, 32'(pix_valid_out), 32'd0);
    chk({tag, "_card_hit"}, 32'(card_hit), 32'd0);
  endtask

  logic [4:0] vis_pat;
  logic [2:0] saved_bg;
  int         px, py;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 3'($urandom_range(0, 7));
    mem[0]  = 3'b101;
    mem[17] = 3'b000;
    mem_if.dataOut = 3'b000;

    reset_n = 1'b0;
    show = 1'b0; blink_en = 1'b0; pos_x = '0; pos_y = '0;
    idle_inputs();
    repeat (2) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
    model_reset();
    repeat (3) cycle();

    // Place at (100,50), turn on.
    idle_inputs(); pos_load = 1'b1; pos_x = 9'd100; pos_y = 8'd50; cycle();
    idle_inputs(); show = 1'b1; frame_start = 1'b1; cycle();
    pixel(100, 50); cycle();
    chk("addr_100_50", 32'(mem_if.rAddr), 32'd0);
    chk("re_100_50", 32'(mem_if.RE), 32'd1);
    idle_inputs(); cycle();
    idle_inputs(); cycle();
    chk("color_100_50", 32'(pix_color), 32'h5);
    chk("hit_100_50", 32'(card_hit), 32'd1);
    pixel(115, 81); cycle();
    chk("addr_115_81", 32'(mem_if.rAddr), 32'd511);
    pixel(116, 81); cycle();
    pixel(115, 82); cycle();
    pixel(99, 50); cycle();
    repeat (3) begin idle_inputs(); cycle(); end

    // Mid-frame load must wait for the next frame_start.
    idle_inputs(); pos_load = 1'b1; pos_x = 9'd250; pos_y = 8'd230; cycle();
    pixel(100, 50); cycle();
    pixel(255, 239); cycle();
    idle_inputs(); frame_start = 1'b1; cycle();
    pixel(255, 239); cycle();
    chk("addr_255_239", 32'(mem_if.rAddr), 32'd149);
    pixel(5, 0); cycle();
    pixel(250, 230); cycle();
    pixel(249, 230); cycle();

    // Load and frame_start together bypass the pending registers.
    idle_inputs(); frame_start = 1'b1; pos_load = 1'b1; pos_x = 9'd10; pos_y = 8'd10; cycle();
    pixel(10, 10); cycle();
    chk("addr_bypass", 32'(mem_if.rAddr), 32'd0);
    chk("re_bypass", 32'(mem_if.RE), 32'd1);

    // Transparent texel at (11,11) -> address 17.
    pixel(11, 11); saved_bg = bg_color; cycle();
    idle_inputs(); cycle();
    idle_inputs(); cycle();
    chk("transp_color", 32'(pix_color), 32'(saved_bg));
    chk("transp_hit", 32'(card_hit), 32'd0);
    chk("transp_valid", 32'(pix_valid_out), 32'd1);
    repeat (2) begin idle_inputs(); cycle(); end

    // Blink: off, then turn on with blinking; frames go V,V,H,H,V.
    idle_inputs(); show = 1'b0; frame_start = 1'b1; cycle();
    show = 1'b1; blink_en = 1'b1;
    vis_pat = 5'b10011;
    for (int f = 0; f < 5; f++) begin
      idle_inputs(); frame_start = 1'b1; cycle();
      pixel(12, 20); cycle();
      chk($sformatf("blink_f%0d", f), 32'(mem_if.RE), 32'(vis_pat[f]));
      pixel(9, 20); cycle();
    end
    idle_inputs(); show = 1'b0; frame_start = 1'b1; cycle();
    pixel(12, 20); cycle();
    chk("off_after_show0", 32'(mem_if.RE), 32'd0);
    repeat (3) begin idle_inputs(); cycle(); end

    // Random traffic around the current card.
    for (int i = 0; i < 400; i++) begin
      frame_start = ($urandom_range(0, 19) == 0);
      pos_load    = ($urandom_range(0, 14) == 0);
      pos_x       = 9'($urandom_range(0, 255));
      pos_y       = 8'($urandom_range(0, 239));
      show        = ($urandom_range(0, 7) != 0);
      blink_en    = ($urandom_range(0, 1) != 0);
      px = m_cur_x - 4 + int'($urandom_range(0, 24));
      py = m_cur_y - 4 + int'($urandom_range(0, 40));
      if (px < 0) px = 0;
      if (px > 255) px = 255;
      if (py < 0) py = 0;
      if (py > 239) py = 239;
      pix_x     = 9'(px);
      pix_y     = 8'(py);
      pix_valid = ($urandom_range(0, 3) != 0);
      bg_color  = 3'($urandom_range(0, 7));
      cycle();
    end

    // Asynchronous reset in the middle of a busy frame.
    idle_inputs(); show = 1'b1; blink_en = 1'b0; frame_start = 1'b1;
    pos_load = 1'b1; pos_x = 9'd0; pos_y = 8'd0; cycle();
    pixel(3, 3); cycle();
    pixel(4, 3); cycle();
    pixel(5, 3);
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clock);
    #1;
    check_all_zero("reset_held");
    reset_n = 1'b1;
    model_reset();
    pixel(3, 3); cycle();
    idle_inputs(); frame_start = 1'b1; show = 1'b1; cycle();
    for (int i = 0; i < 6; i++) begin pixel(i, i); cycle(); end
    repeat (3) begin idle_inputs(); cycle(); end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
